// File: rtl/axi_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// axi_pkg : shared types for the axi_slave_mem responder
// Rev 1.0
// ============================================================================
package axi_pkg;
    localparam int ID_W  = 9;
    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;
endpackage
`default_nettype wire

// File: rtl/axi_slave_mem_burst_addr.sv
`default_nettype none
// ============================================================================
// axi_burst_addr : next-beat address and whole-burst legality check
// Rev 1.0
// ============================================================================
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int A_WIDTH = 16,
    parameter int D_WIDTH = 16
) (
    input  logic [A_WIDTH-1:0] addr_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [2:0]         size_i,
    input  logic [1:0]         burst_i,
    output logic [A_WIDTH-1:0] next_addr_o,
    output logic               burst_err_o
);
    localparam int SZ_MAX = $clog2(D_WIDTH/8);

    logic [A_WIDTH-1:0] w_step;
    logic [A_WIDTH-1:0] w_mask;
    logic [A_WIDTH-1:0] w_inc;

    always_comb begin
        w_step = {{(A_WIDTH-1){1'b0}}, 1'b1} << size_i;
        // wrap window is (LEN+1)*step bytes; only power-of-two lengths are legal
        w_mask = (({{(A_WIDTH-LEN_W){1'b0}}, len_i} + 1'b1) << size_i) - 1'b1;
        w_inc  = addr_i + w_step;
        case (burst_i)
            INCR:    next_addr_o = w_inc;
            WRAP:    next_addr_o = (addr_i & ~w_mask) | (w_inc & w_mask);
            default: next_addr_o = addr_i;
        endcase
        burst_err_o = (burst_i == 2'b11)
                   || ((burst_i == WRAP) && !(len_i inside {4'd1, 4'd3, 4'd7, 4'd15}))
                   || (size_i > 3'(SZ_MAX));
    end
endmodule
`default_nettype wire

// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
// axi_slave_mem : AXI responder backed by a word-addressed memory
// Rev 1.0
// ============================================================================
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int A_WIDTH   = 16,
    parameter int D_WIDTH   = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [ID_W-1:0]      AWID,
    input  logic [A_WIDTH-1:0]   AWADDR,
    input  logic [LEN_W-1:0]     AWLEN,
    input  logic [2:0]           AWSIZE,
    input  logic [1:0]           AWBURST,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [ID_W-1:0]      WID,
    input  logic [D_WIDTH-1:0]   WDATA,
    input  logic [D_WIDTH/8-1:0] WSTRB,
    input  logic                 WLAST,
    input  logic                 WVALID,
    output logic                 WREADY,
    output logic [ID_W-1:0]      BID,
    output logic [1:0]           BRESP,
    output logic                 BVALID,
    input  logic                 BREADY,
    input  logic [ID_W-1:0]      ARID,
    input  logic [A_WIDTH-1:0]   ARADDR,
    input  logic [LEN_W-1:0]     ARLEN,
    input  logic [2:0]           ARSIZE,
    input  logic [1:0]           ARBURST,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [ID_W-1:0]      RID,
    output logic [D_WIDTH-1:0]   RDATA,
    output logic [1:0]           RRESP,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY
);
    localparam int STRB_W = D_WIDTH/8;
    localparam int SH     = $clog2(STRB_W);
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    logic [D_WIDTH-1:0] mem_q [MEM_DEPTH];

    wr_state_e          wstate_q, wstate_d;
    logic               awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0]    bid_q, bid_d, wid_q, wid_d;
    logic [1:0]         bresp_q, bresp_d, wburst_q, wburst_d;
    logic [A_WIDTH-1:0] waddr_q, waddr_d;
    logic [LEN_W-1:0]   wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]         wsize_q, wsize_d;
    logic               werr_q, werr_d;

    rd_state_e          rstate_q, rstate_d;
    logic               arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0]    rid_q, rid_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d, rburst_q, rburst_d;
    logic [A_WIDTH-1:0] raddr_q, raddr_d;
    logic [LEN_W-1:0]   rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]         rsize_q, rsize_d;

    logic [A_WIDTH-1:0] w_wr_next, w_wr_idx;
    logic               w_wr_burst_err, w_wr_beat_err, w_wr_last, w_mem_we;

    axi_burst_addr #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_wr_addr (
        .addr_i(waddr_q), .len_i(wlen_q), .size_i(wsize_q), .burst_i(wburst_q),
        .next_addr_o(w_wr_next), .burst_err_o(w_wr_burst_err)
    );

    assign w_wr_idx      = waddr_q >> SH;
    assign w_wr_beat_err = w_wr_burst_err || (w_wr_idx >= A_WIDTH'(MEM_DEPTH));
    assign w_wr_last     = (wcnt_q == wlen_q);

    // In idle the read calculator looks at the incoming AR so beat 0 is ready at the handshake
    logic               w_rd_idle, w_rd_burst_err, w_rd_beat_err;
    logic [A_WIDTH-1:0] w_rd_next, w_rd_beat_addr, w_rd_idx;
    logic [D_WIDTH-1:0] w_rd_word;

    assign w_rd_idle = (rstate_q == R_IDLE);

    axi_burst_addr #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_rd_addr (
        .addr_i (w_rd_idle ? ARADDR  : raddr_q),
        .len_i  (w_rd_idle ? ARLEN   : rlen_q),
        .size_i (w_rd_idle ? ARSIZE  : rsize_q),
        .burst_i(w_rd_idle ? ARBURST : rburst_q),
        .next_addr_o(w_rd_next), .burst_err_o(w_rd_burst_err)
    );

    assign w_rd_beat_addr = w_rd_idle ? ARADDR : w_rd_next;
    assign w_rd_idx       = w_rd_beat_addr >> SH;
    assign w_rd_beat_err  = w_rd_burst_err || (w_rd_idx >= A_WIDTH'(MEM_DEPTH));
    assign w_rd_word      = w_rd_beat_err ? '0 : mem_q[w_rd_idx[MEM_AW-1:0]];

    always_comb begin
        wstate_d = wstate_q; awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
        bid_d = bid_q; bresp_d = bresp_q; wid_d = wid_q; waddr_d = waddr_q; wlen_d = wlen_q;
        wsize_d = wsize_q; wburst_d = wburst_q; wcnt_d = wcnt_q; werr_d = werr_q; w_mem_we = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (awready_q && AWVALID) begin
                    wid_d = AWID; waddr_d = AWADDR; wlen_d = AWLEN; wsize_d = AWSIZE;
                    wburst_d = AWBURST; wcnt_d = '0; werr_d = 1'b0;
                    awready_d = 1'b0; wready_d = 1'b1; wstate_d = W_DATA;
                end else begin
                    awready_d = 1'b1;
                end
            end
            W_DATA: begin
                if (WVALID && wready_q) begin
                    w_mem_we = !w_wr_beat_err;
                    werr_d   = werr_q || w_wr_beat_err || (WLAST != w_wr_last) || (WID != wid_q);
                    if (w_wr_last) begin
                        wready_d = 1'b0; bvalid_d = 1'b1; bid_d = wid_q;
                        bresp_d  = werr_d ? SLVERR : OKAY;
                        wstate_d = W_RESP;
                    end else begin
                        wcnt_d  = wcnt_q + 1'b1;
                        waddr_d = w_wr_next;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
        rid_d = rid_q; rdata_d = rdata_q; rresp_d = rresp_q; raddr_d = raddr_q;
        rlen_d = rlen_q; rsize_d = rsize_q; rburst_d = rburst_q; rcnt_d = rcnt_q;
        case (rstate_q)
            R_IDLE: begin
                if (arready_q && ARVALID) begin
                    rid_d = ARID; raddr_d = ARADDR; rlen_d = ARLEN; rsize_d = ARSIZE;
                    rburst_d = ARBURST; rcnt_d = '0; arready_d = 1'b0; rvalid_d = 1'b1;
                    rdata_d = w_rd_word; rresp_d = w_rd_beat_err ? SLVERR : OKAY;
                    rlast_d = (ARLEN == '0); rstate_d = R_DATA;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0; rlast_d = 1'b0; arready_d = 1'b1; rstate_d = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + 1'b1;
                        raddr_d = w_rd_next;
                        rdata_d = w_rd_word;
                        rresp_d = w_rd_beat_err ? SLVERR : OKAY;
                        rlast_d = ((rcnt_q + 1'b1) == rlen_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q <= W_IDLE; awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
            bid_q <= '0; bresp_q <= '0; wid_q <= '0; waddr_q <= '0; wlen_q <= '0;
            wsize_q <= '0; wburst_q <= '0; wcnt_q <= '0; werr_q <= 1'b0;
            rstate_q <= R_IDLE; arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
            rid_q <= '0; rdata_q <= '0; rresp_q <= '0; raddr_q <= '0; rlen_q <= '0;
            rsize_q <= '0; rburst_q <= '0; rcnt_q <= '0;
        end else begin
            wstate_q <= wstate_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
            bid_q <= bid_d; bresp_q <= bresp_d; wid_q <= wid_d; waddr_q <= waddr_d; wlen_q <= wlen_d;
            wsize_q <= wsize_d; wburst_q <= wburst_d; wcnt_q <= wcnt_d; werr_q <= werr_d;
            rstate_q <= rstate_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
            rid_q <= rid_d; rdata_q <= rdata_d; rresp_q <= rresp_d; raddr_q <= raddr_d; rlen_q <= rlen_d;
            rsize_q <= rsize_d; rburst_q <= rburst_d; rcnt_q <= rcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem_q[w_wr_idx[MEM_AW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
// tb_axi_slave_mem : directed scoreboard bench for axi_slave_mem
// Rev 1.0
// ============================================================================
module tb_axi_slave_mem;
    logic        clk = 1'b0;
    logic        rstn;
    logic [8:0]  AWID, WID, BID, ARID, RID;
    logic [15:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, WSTRB, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    axi_slave_mem #(.A_WIDTH(16), .D_WIDTH(16), .MEM_DEPTH(256)) dut (
        .clk(clk), .rstn(rstn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] data; logic [1:0] resp; logic last; logic [8:0] id; } rexp_t;
    typedef struct { logic [8:0] id; logic [1:0] resp; } bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];
    logic [15:0] wd [16];
    int checks = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic push_r(input logic [15:0] d, input logic [1:0] r, input logic l, input logic [8:0] id);
        rexp_t e;
        e.data = d; e.resp = r; e.last = l; e.id = id;
        rq.push_back(e);
    endtask

    task automatic push_b(input logic [8:0] id, input logic [1:0] r);
        bexp_t e;
        e.id = id; e.resp = r;
        bq.push_back(e);
    endtask

    task automatic send_aw(input logic [8:0] id, input logic [15:0] a, input logic [3:0] len, input logic [1:0] bt);
        int n = 0;
        AWID = id; AWADDR = a; AWLEN = len; AWSIZE = 3'd1; AWBURST = bt; AWVALID = 1'b1;
        while (!AWREADY && n < 20) begin tick(); n++; end
        if (!AWREADY) timeout("aw_handshake"); else tick();
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [15:0] d, input logic [1:0] s, input logic l, input logic [8:0] id);
        int n = 0;
        WDATA = d; WSTRB = s; WLAST = l; WID = id; WVALID = 1'b1;
        while (!WREADY && n < 20) begin tick(); n++; end
        if (!WREADY) timeout("w_handshake"); else tick();
        WVALID = 1'b0;
    endtask

    task automatic write_burst(input logic [8:0] id, input logic [15:0] a, input logic [3:0] len,
                               input logic [1:0] bt, input int last_at);
        send_aw(id, a, len, bt);
        for (int i = 0; i <= int'(len); i++) send_w(wd[i], 2'b11, (i == last_at), id);
    endtask

    task automatic collect_b(input int stall);
        bexp_t e;
        int n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        if (!BVALID) begin timeout("b_valid"); void'(bq.pop_front()); return; end
        e = bq.pop_front();
        for (int k = 0; k < stall; k++) begin
            tick();
            chk("b_stall_valid", {31'd0, BVALID}, 32'd1);
            chk("b_stall_id", {23'd0, BID}, {23'd0, e.id});
            chk("b_stall_resp", {30'd0, BRESP}, {30'd0, e.resp});
        end
        BREADY = 1'b1;
        chk("bid", {23'd0, BID}, {23'd0, e.id});
        chk("bresp", {30'd0, BRESP}, {30'd0, e.resp});
        tick();
        BREADY = 1'b0;
        chk("b_dead_cycle_awready", {31'd0, AWREADY}, 32'd0);
        tick();
        chk("awready_after_b", {31'd0, AWREADY}, 32'd1);
    endtask

    task automatic send_ar(input logic [8:0] id, input logic [15:0] a, input logic [3:0] len, input logic [1:0] bt);
        int n = 0;
        ARID = id; ARADDR = a; ARLEN = len; ARSIZE = 3'd1; ARBURST = bt; ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin tick(); n++; end
        if (!ARREADY) timeout("ar_handshake"); else tick();
        ARVALID = 1'b0;
        chk("r_latency_valid", {31'd0, RVALID}, 32'd1);
    endtask

    task automatic collect_r(input int nb, input int stall_beat, input int stall_len);
        rexp_t e;
        for (int i = 0; i < nb; i++) begin
            int n = 0;
            while (!RVALID && n < 20) begin tick(); n++; end
            if (!RVALID) begin timeout("r_valid"); rq.delete(); return; end
            e = rq.pop_front();
            if (i == stall_beat) begin
                RREADY = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    tick();
                    chk("r_stall_valid", {31'd0, RVALID}, 32'd1);
                    chk("r_stall_data", {16'd0, RDATA}, {16'd0, e.data});
                    chk("r_stall_id", {23'd0, RID}, {23'd0, e.id});
                    chk("r_stall_last", {31'd0, RLAST}, {31'd0, e.last});
                end
            end
            RREADY = 1'b1;
            chk("rdata", {16'd0, RDATA}, {16'd0, e.data});
            chk("rresp", {30'd0, RRESP}, {30'd0, e.resp});
            chk("rlast", {31'd0, RLAST}, {31'd0, e.last});
            chk("rid", {23'd0, RID}, {23'd0, e.id});
            tick();
            RREADY = 1'b0;
            if (i < nb - 1) chk("r_no_bubble", {31'd0, RVALID}, 32'd1);
        end
        chk("r_done_valid", {31'd0, RVALID}, 32'd0);
        chk("r_done_arready", {31'd0, ARREADY}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {20'd0, AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BRESP, RRESP, 2'b00},
            32'd0);
        chk(tag, {5'd0, BID, RID, 9'd0}, 32'd0);
        chk(tag, {16'd0, RDATA}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (2) tick();
        chk_all_zero("reset_outputs");
        rstn = 1'b1;
        chk("ready_before_edge", {30'd0, AWREADY, ARREADY}, 32'd0);
        tick();
        chk("ready_after_edge", {30'd0, AWREADY, ARREADY}, 32'd3);

        // 1: INCR write/read
        wd[0] = 16'd1; wd[1] = 16'd2; wd[2] = 16'd3; wd[3] = 16'd4;
        push_b(9'd5, 2'b00);
        write_burst(9'd5, 16'h0010, 4'd3, 2'b01, 3);
        collect_b(0);
        push_r(16'd1, 2'b00, 1'b0, 9'd5); push_r(16'd2, 2'b00, 1'b0, 9'd5);
        push_r(16'd3, 2'b00, 1'b0, 9'd5); push_r(16'd4, 2'b00, 1'b1, 9'd5);
        send_ar(9'd5, 16'h0010, 4'd3, 2'b01);
        collect_r(4, -1, 0);

        // 2: WRAP write lands at 0x0C,0x0E,0x08,0x0A
        wd[0] = 16'h000A; wd[1] = 16'h000B; wd[2] = 16'h000C; wd[3] = 16'h000D;
        push_b(9'd2, 2'b00);
        write_burst(9'd2, 16'h000C, 4'd3, 2'b10, 3);
        collect_b(0);
        push_r(16'h000C, 2'b00, 1'b0, 9'd3); push_r(16'h000D, 2'b00, 1'b0, 9'd3);
        push_r(16'h000A, 2'b00, 1'b0, 9'd3); push_r(16'h000B, 2'b00, 1'b1, 9'd3);
        send_ar(9'd3, 16'h0008, 4'd3, 2'b01);
        collect_r(4, -1, 0);

        // 3: second beat falls off the end of memory
        wd[0] = 16'h1234; wd[1] = 16'h5678;
        push_b(9'd4, 2'b10);
        write_burst(9'd4, 16'h01FE, 4'd1, 2'b01, 1);
        collect_b(0);
        push_r(16'h1234, 2'b00, 1'b0, 9'd4); push_r(16'h0000, 2'b10, 1'b1, 9'd4);
        send_ar(9'd4, 16'h01FE, 4'd1, 2'b01);
        collect_r(2, -1, 0);

        // 4: back-pressure on R and B
        push_r(16'd1, 2'b00, 1'b0, 9'd9); push_r(16'd2, 2'b00, 1'b0, 9'd9);
        push_r(16'd3, 2'b00, 1'b0, 9'd9); push_r(16'd4, 2'b00, 1'b1, 9'd9);
        send_ar(9'd9, 16'h0010, 4'd3, 2'b01);
        collect_r(4, 1, 3);
        wd[0] = 16'h0055; wd[1] = 16'h0066;
        push_b(9'd1, 2'b00);
        write_burst(9'd1, 16'h0020, 4'd1, 2'b01, 1);
        collect_b(2);

        // 5: early WLAST still takes all beats; reserved burst type writes nothing
        wd[0] = 16'h0011; wd[1] = 16'h0022; wd[2] = 16'h0033; wd[3] = 16'h0044;
        push_b(9'd6, 2'b10);
        write_burst(9'd6, 16'h0040, 4'd3, 2'b01, 1);
        collect_b(0);
        push_r(16'h0011, 2'b00, 1'b0, 9'd6); push_r(16'h0022, 2'b00, 1'b0, 9'd6);
        push_r(16'h0033, 2'b00, 1'b0, 9'd6); push_r(16'h0044, 2'b00, 1'b1, 9'd6);
        send_ar(9'd6, 16'h0040, 4'd3, 2'b01);
        collect_r(4, -1, 0);
        wd[0] = 16'hDEAD;
        push_b(9'd6, 2'b10);
        write_burst(9'd6, 16'h0010, 4'd0, 2'b11, 0);
        collect_b(0);
        push_r(16'd1, 2'b00, 1'b1, 9'd6);
        send_ar(9'd6, 16'h0010, 4'd0, 2'b01);
        collect_r(1, -1, 0);

        // 6: reset in the middle of both bursts
        send_ar(9'd8, 16'h0010, 4'd3, 2'b01);
        RREADY = 1'b1;
        chk("t6_rdata0", {16'd0, RDATA}, 32'd1);
        tick();
        chk("t6_rdata1", {16'd0, RDATA}, 32'd2);
        tick();
        RREADY = 1'b0;
        chk("t6_rdata2", {16'd0, RDATA}, 32'd3);
        send_aw(9'd7, 16'h0060, 4'd3, 2'b01);
        send_w(16'h0071, 2'b11, 1'b0, 9'd7);
        send_w(16'h0072, 2'b11, 1'b0, 9'd7);
        WDATA = 16'h0073; WSTRB = 2'b11; WID = 9'd7; WVALID = 1'b1; RREADY = 1'b1;
        #2 rstn = 1'b0;
        #1 chk_all_zero("t6_async_reset");
        WVALID = 1'b0; RREADY = 1'b0;
        tick();
        rstn = 1'b1;
        chk("t6_ready_before_edge", {30'd0, AWREADY, ARREADY}, 32'd0);
        tick();
        chk("t6_ready_after_edge", {30'd0, AWREADY, ARREADY}, 32'd3);
        push_r(16'h0071, 2'b00, 1'b0, 9'd8); push_r(16'h0072, 2'b00, 1'b1, 9'd8);
        send_ar(9'd8, 16'h0060, 4'd1, 2'b01);
        collect_r(2, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
